// File: rtl/disp_scan_ctrl_pkg.sv
// disp_scan_ctrl_pkg: shared state encodings and defaults for the display scan controller
package disp_scan_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_PRESCALE = 16;
    localparam int DEF_DATA_W = 8;
    localparam logic [DEF_DATA_W-1:0] BLANK_PAT = '0;
endpackage

// File: rtl/disp_regfile.sv
// disp_regfile: shadow/active digit files with a write port and a deferred commit copy
module disp_regfile
    import disp_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int DATA_W = DEF_DATA_W,
    localparam int AW = $clog2(NUM_DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              commit,
    input  logic              copy_ok,
    output logic              commit_done,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] shadow [NUM_DIGITS];
    logic [DATA_W-1:0] active [NUM_DIGITS];
    logic pending;
    logic do_copy;

    assign wr_ready = !pending;
    assign do_copy  = pending && copy_ok;
    assign rd_data  = active[rd_addr];

    // an address outside the file matches no entry, so such writes vanish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            commit_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            commit_done <= do_copy;
            if (do_copy) begin
                active <= shadow;
                pending <= 1'b0;
            end else if (commit) begin
                pending <= 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++)
                if (wr_en && wr_ready && int'(wr_addr) == i) shadow[i] <= wr_data;
        end
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed digit scanner with blanking gaps and tear-free frame commits
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int DATA_W = DEF_DATA_W,
    localparam int AW = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_ready,
    input  logic                  commit,
    output logic                  commit_done,
    output logic [DATA_W-1:0]     conv_in,
    input  logic [DATA_W-1:0]     conv_out,
    output logic [DATA_W-1:0]     seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_done
);
    localparam int CW = $clog2(PRESCALE + 1);

    state_t state;
    logic [AW-1:0] k;
    logic [CW-1:0] cnt;
    logic last_k, last_cnt, copy_ok;

    assign last_k   = k == AW'(NUM_DIGITS - 1);
    assign last_cnt = cnt == CW'(PRESCALE - 1);
    // copies land only between frames: while idle, or on the wrap out of the last blank
    assign copy_ok  = state == IDLE || (state == BLANK && enable && last_k);

    disp_regfile #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W)) u_regfile (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .commit(commit),
        .copy_ok(copy_ok),
        .commit_done(commit_done),
        .rd_addr(k),
        .rd_data(conv_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k <= '0;
            cnt <= '0;
            seg_out <= '0;
            dig_sel <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out <= DATA_W'(BLANK_PAT);
            dig_sel <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    state <= DRIVE;
                    k <= '0;
                    cnt <= '0;
                end
                DRIVE: if (!enable) begin
                    state <= IDLE;
                    k <= '0;
                    cnt <= '0;
                end else begin
                    seg_out <= conv_out;
                    dig_sel <= NUM_DIGITS'(1) << k;
                    cnt <= cnt + 1'b1;
                    if (last_cnt) state <= BLANK;
                end
                BLANK: if (!enable) begin
                    state <= IDLE;
                    k <= '0;
                    cnt <= '0;
                end else begin
                    state <= DRIVE;
                    cnt <= '0;
                    k <= last_k ? '0 : k + 1'b1;
                    frame_done <= last_k;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboarded bench; stimulus queues expected output cycles, a monitor pops them
module tb_disp_scan_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, wr_en = 1'b0, commit = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic wr_ready, commit_done, frame_done;
    logic [7:0] conv_in, conv_out, seg_out;
    logic [3:0] dig_sel;

    typedef struct packed {logic [3:0] dig; logic [7:0] seg; logic cd; logic fd;} exp_t;
    exp_t q[$];
    exp_t e;
    int n_vec = 0, n_err = 0;

    disp_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .commit(commit), .commit_done(commit_done),
        .conv_in(conv_in), .conv_out(conv_out), .seg_out(seg_out), .dig_sel(dig_sel),
        .frame_done(frame_done)
    );

    // converter stand-in: nibble swap xor 3C, so 0C->FC, 55->69, FF->C3, 00->3C, AA->96
    assign conv_out = {conv_in[3:0], conv_in[7:4]} ^ 8'h3C;

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] d, input logic [7:0] s, input logic cd, input logic fd, input int n);
        repeat (n) q.push_back(exp_t'({d, s, cd, fd}));
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h expected %h", nm, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (dig_sel != 0 || commit_done || frame_done)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got dig=%b seg=%h cd=%b fd=%b expected none",
                         dig_sel, seg_out, commit_done, frame_done);
            end else begin
                e = q.pop_front();
                if ({dig_sel, seg_out, commit_done, frame_done} !== e) begin
                    n_err++;
                    $display("FAIL scan_output got dig=%b seg=%h cd=%b fd=%b expected dig=%b seg=%h cd=%b fd=%b",
                             dig_sel, seg_out, commit_done, frame_done, e.dig, e.seg, e.cd, e.fd);
                end
            end
        end
    end

    initial begin
        // reset held with enable high, then scanning of the all-zero file starts
        push(4'b0001, 8'h3C, 1'b0, 1'b0, 4);
        cyc(3);
        chk("reset_seg", seg_out, 0);
        chk("reset_dig", dig_sel, 0);
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_conv_in", conv_in, 0);
        rst_n = 1'b1;
        cyc(5);
        enable = 1'b0;
        cyc(3);
        chk("t1_drained", q.size(), 0);
        // idle commit
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h0C;
        cyc(1);
        wr_addr = 2'd1; wr_data = 8'h55;
        cyc(1);
        wr_en = 1'b0;
        push(4'b0000, 8'h00, 1'b1, 1'b0, 1);
        commit = 1'b1;
        cyc(1);
        commit = 1'b0;
        chk("t2_pending_ready", wr_ready, 0);
        cyc(1);
        chk("t2_ready_back", wr_ready, 1);
        chk("t2_conv_in", conv_in, 8'h0C);
        cyc(1);
        chk("t2_commit_done_single", commit_done, 0);
        // three frames of expected output, incl. the mid-frame commit taking effect in frame 3
        push(4'b0001, 8'hFC, 1'b0, 1'b0, 4);
        push(4'b0010, 8'h69, 1'b0, 1'b0, 4);
        push(4'b0100, 8'h3C, 1'b0, 1'b0, 4);
        push(4'b1000, 8'h3C, 1'b0, 1'b0, 4);
        push(4'b0000, 8'h00, 1'b0, 1'b1, 1);
        push(4'b0001, 8'hFC, 1'b0, 1'b0, 4);
        push(4'b0010, 8'h69, 1'b0, 1'b0, 4);
        push(4'b0100, 8'h3C, 1'b0, 1'b0, 4);
        push(4'b1000, 8'h3C, 1'b0, 1'b0, 4);
        push(4'b0000, 8'h00, 1'b1, 1'b1, 1);
        push(4'b0001, 8'hFC, 1'b0, 1'b0, 4);
        push(4'b0010, 8'h69, 1'b0, 1'b0, 4);
        push(4'b0100, 8'hC3, 1'b0, 1'b0, 2);
        enable = 1'b1;
        cyc(27);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF; commit = 1'b1;
        cyc(1);
        chk("t4_stall", wr_ready, 0);
        wr_addr = 2'd3; wr_data = 8'hAA; commit = 1'b0;
        cyc(1);
        wr_en = 1'b0;
        cyc(11);
        chk("t4_stall_to_frame_end", wr_ready, 0);
        cyc(1);
        chk("t4_ready_after_copy", wr_ready, 1);
        cyc(12);
        // enable drop in digit 2
        enable = 1'b0;
        cyc(1);
        chk("t5_dig_off", dig_sel, 0);
        chk("t5_seg_off", seg_out, 0);
        cyc(25);
        chk("t5_all_popped", q.size(), 0);
        chk("t5_no_frame_done", frame_done, 0);
        // re-enable restarts at digit 0, then async reset mid-dwell
        push(4'b0001, 8'hFC, 1'b0, 1'b0, 2);
        enable = 1'b1;
        cyc(3);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_dig_async", dig_sel, 0);
        chk("t6_seg_async", seg_out, 0);
        chk("t6_active_cleared", conv_in, 0);
        chk("t6_wr_ready", wr_ready, 1);
        chk("t6_restart_popped", q.size(), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        chk("t6_active_stays_zero", conv_in, 0);
        chk("t6_idle_dig", dig_sel, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
